lifo_stack: RTL and testbench

Synchronous last-in/first-out storage block holding up to DEPTH words of WIDTH bits, with push/pop strobes and full/empty status. It serves as a local operand or return-address stack inside the datapath. One push or pop is accepted per clock. Popped data appears on a registered output.

---
 rtl/lifo_stack_pkg.sv | 36 +++
 rtl/lifo_stack_ram.sv | 29 ++
 rtl/lifo_stack.sv | 110 +++++++++++
 tb/tb_lifo_stack.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lifo_stack_pkg.sv
// Shared constants and operation decode for the lifo_stack block.
package lifo_stack_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } op_e;

    // Resolves the strobes against the current status. Push and pop together
    // on an empty stack degrade to a plain push. When both strobes are high
    // and the stack is not empty, the result is a replace-top, which is legal
    // even when the stack is full.
    function automatic op_e decode_op(
        input logic push,
        input logic pop,
        input logic empty,
        input logic full
    );
        op_e op;
        op = OP_NONE;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPL;
        end else if (push) begin
            op = full ? OP_NONE : OP_PUSH;
        end else if (pop) begin
            op = empty ? OP_NONE : OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/lifo_stack_ram.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port.
module lifo_stack_ram #(
    parameter int WIDTH = lifo_stack_pkg::DEFAULT_WIDTH,
    parameter int DEPTH = lifo_stack_pkg::DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose. Contents are only meaningful
    // below the stack pointer, and leaving the array without a reset lets it
    // map onto plain storage cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO stack with push/pop strobes, registered pop data and
// full/empty flags. Define STACK_ERR_FLAG_EN to add a sticky err output.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] value_in,
    output logic [WIDTH-1:0] value_out,
    output logic             full,
    output logic             empty
`ifdef STACK_ERR_FLAG_EN
    ,
    output logic             err
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   sp_next;
    logic [SPW-1:0]   sp_dec;
    logic [WIDTH-1:0] top_data;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [AW-1:0]    top_addr;
    logic             load_out;
    op_e              op;

    assign empty  = (sp == '0);
    assign full   = (sp == SPW'(DEPTH));
    assign sp_dec = sp - 1'b1;

    // The read address wraps when sp is 0; the data is never used then.
    assign top_addr = sp_dec[AW-1:0];

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        op        = decode_op(push, pop, empty, full);
        sp_next   = sp;
        ram_we    = 1'b0;
        ram_waddr = sp[AW-1:0];
        load_out  = 1'b0;
        unique case (op)
            OP_PUSH: begin
                ram_we  = 1'b1;
                sp_next = sp + 1'b1;
            end
            OP_POP: begin
                load_out = 1'b1;
                sp_next  = sp_dec;
            end
            OP_REPL: begin
                ram_we    = 1'b1;
                ram_waddr = top_addr;
                load_out  = 1'b1;
            end
            default: ;
        endcase
    end

    lifo_stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (value_in),
        .raddr (top_addr),
        .rdata (top_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order statements appear in.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            value_out <= '0;
        end else begin
            sp <= sp_next;
            if (load_out) begin
                value_out <= top_data;
            end
        end
    end

`ifdef STACK_ERR_FLAG_EN
    // Only a push-only on full or a pop-only on empty counts as an error.
    logic err_set;
    assign err_set = (push && !pop && full) || (pop && !push && empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=16, DEPTH=8).
module tb_lifo_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] value_in;
    logic [WIDTH-1:0] value_out;
    logic             full;
    logic             empty;
`ifdef STACK_ERR_FLAG_EN
    logic             err;
`endif

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .value_in  (value_in),
        .value_out (value_out),
        .full      (full),
        .empty     (empty)
`ifdef STACK_ERR_FLAG_EN
        ,
        .err       (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 ns after the rising edge.
    task automatic cycle(input logic p, input logic q, input logic [WIDTH-1:0] v);
        push     = p;
        pop      = q;
        value_in = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        value_in = '0;

        // Reset held for two cycles, then released.
        cycle(0, 0, 16'h0000);
        cycle(0, 0, 16'h0000);
        reset = 1'b0;
        cycle(0, 0, 16'h0000);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_value_out", value_out, 16'h0000);
`ifdef STACK_ERR_FLAG_EN
        check("rst_err", err, 0);
`endif

        // Overflow: ten pushes of 0x0013, full after the eighth.
        for (int i = 1; i <= 10; i++) begin
            cycle(1, 0, 16'h0013);
            check($sformatf("ovf_full_%0d", i), full, (i >= DEPTH) ? 1 : 0);
            check($sformatf("ovf_empty_%0d", i), empty, 0);
`ifdef STACK_ERR_FLAG_EN
            check($sformatf("ovf_err_%0d", i), err, (i > DEPTH) ? 1 : 0);
`endif
        end

        // Four pops from full.
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 16'h0000);
            check($sformatf("popf_value_%0d", i), value_out, 16'h0013);
            check($sformatf("popf_full_%0d", i), full, 0);
            check($sformatf("popf_empty_%0d", i), empty, 0);
        end
        cycle(0, 0, 16'h0014);
        check("idle_hold", value_out, 16'h0013);

        // Four entries must remain; the stack empties on exactly the fourth pop.
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 16'h0000);
            check($sformatf("drain_value_%0d", i), value_out, 16'h0013);
            check($sformatf("drain_empty_%0d", i), empty, (i == 4) ? 1 : 0);
        end

        // LIFO ordering.
        cycle(1, 0, 16'h0001);
        cycle(1, 0, 16'h0002);
        cycle(1, 0, 16'h0003);
        cycle(0, 1, 16'h0000);
        check("lifo_pop1", value_out, 16'h0003);
        cycle(0, 1, 16'h0000);
        check("lifo_pop2", value_out, 16'h0002);
        check("lifo_empty2", empty, 0);
        cycle(0, 1, 16'h0000);
        check("lifo_pop3", value_out, 16'h0001);
        check("lifo_empty3", empty, 1);

        // Underflow: output holds, pointer stays at zero.
        cycle(0, 1, 16'h0000);
        check("udf_value", value_out, 16'h0001);
        check("udf_empty", empty, 1);
        cycle(1, 0, 16'h00CC);
        cycle(0, 1, 16'h0000);
        check("udf_sp_value", value_out, 16'h00CC);
        check("udf_sp_empty", empty, 1);
`ifdef STACK_ERR_FLAG_EN
        check("udf_err", err, 1);
`endif

        // Replace-top with 0x00AA on top.
        cycle(1, 0, 16'h0011);
        cycle(1, 0, 16'h00AA);
        cycle(1, 1, 16'h00BB);
        check("repl_value", value_out, 16'h00AA);
        check("repl_empty", empty, 0);
        cycle(0, 1, 16'h0000);
        check("repl_pop_new", value_out, 16'h00BB);
        check("repl_pop_new_empty", empty, 0);
        cycle(0, 1, 16'h0000);
        check("repl_pop_below", value_out, 16'h0011);
        check("repl_count_empty", empty, 1);

        // Replace-top while full, with distinct values.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1, 0, WIDTH'(i));
        end
        check("fill_full", full, 1);
        cycle(1, 1, 16'h0055);
        check("repl_full_value", value_out, 16'h0008);
        check("repl_full_flag", full, 1);
        cycle(0, 1, 16'h0000);
        check("repl_full_pop", value_out, 16'h0055);
        check("repl_full_cleared", full, 0);
        cycle(0, 1, 16'h0000);
        check("repl_full_below", value_out, 16'h0007);

        // Push and pop together on empty acts as a push.
        reset = 1'b1;
        cycle(0, 0, 16'h0000);
        reset = 1'b0;
        check("rst2_value", value_out, 16'h0000);
`ifdef STACK_ERR_FLAG_EN
        check("rst2_err", err, 0);
`endif
        cycle(1, 1, 16'h0077);
        check("pp_empty_flag", empty, 0);
        check("pp_empty_value", value_out, 16'h0000);
`ifdef STACK_ERR_FLAG_EN
        check("pp_empty_err", err, 0);
`endif
        cycle(0, 1, 16'h0000);
        check("pp_empty_pop", value_out, 16'h0077);
        check("pp_empty_after", empty, 1);

        // Reset wins over a simultaneous push.
        cycle(1, 0, 16'h0021);
        cycle(1, 0, 16'h0022);
        reset = 1'b1;
        cycle(1, 0, 16'h0023);
        reset = 1'b0;
        check("rst_push_empty", empty, 1);
        check("rst_push_full", full, 0);
        cycle(0, 1, 16'h0000);
        check("rst_push_pop_ignored", value_out, 16'h0000);
        check("rst_push_still_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
